// File: rtl/ex_merge_fifo_pkg.sv
// Shared types and defaults for the EX-stage merge buffer.
// EX_PACKET carries one functional-unit result toward the complete/CDB stage.
package ex_merge_fifo_pkg;

    localparam int EX_FIFO_DEPTH  = 8;
    localparam int EX_FIFO_IN_CH  = 2;
    localparam int EX_FIFO_OUT_CH = 1;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] npc;
        logic [4:0]  dest_reg_idx;
        logic [3:0]  rob_tag;
        logic        take_branch;
        logic        halt;
        logic        illegal;
    } EX_PACKET;

    // Used for reset contents and for the packet field of invalid lanes.
    localparam EX_PACKET EX_PACKET_ZERO = '0;

endpackage

// File: rtl/ex_merge_fifo_lane_compactor.sv
// Packs the valid lanes of a packet vector toward index 0, keeping their
// relative order, and reports how many lanes were valid.
module ex_merge_fifo_lane_compactor
    import ex_merge_fifo_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]             valid,
    input  EX_PACKET                 packet  [N],
    output EX_PACKET                 compact [N],
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CNTW = $clog2(N+1);

    logic [CNTW-1:0] acc;

    // acc is the slot the next valid lane lands in.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
            compact[k] = EX_PACKET_ZERO;
        end
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                for (int k = 0; k < N; k++) begin
                    if (acc == CNTW'(k)) begin
                        compact[k] = packet[i];
                    end
                end
                acc = acc + CNTW'(1);
            end
        end
        count = acc;
    end

endmodule

// File: rtl/ex_merge_fifo.sv
// N-in / M-out ordered merge buffer between the functional units and the
// complete stage: circular storage, optional empty-bypass, flush and overflow flag.
module ex_merge_fifo
    import ex_merge_fifo_pkg::*;
#(
    parameter int DEPTH  = EX_FIFO_DEPTH,
    parameter int IN_CH  = EX_FIFO_IN_CH,
    parameter int OUT_CH = EX_FIFO_OUT_CH,
    parameter int BYPASS = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [IN_CH-1:0]           in_valid,
    input  EX_PACKET                   in_packet  [IN_CH],
    output logic                       in_ready,
    output logic [OUT_CH-1:0]          out_valid,
    output EX_PACKET                   out_packet [OUT_CH],
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(IN_CH + 1);
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - IN_CH);

    EX_PACKET        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic [IN_CH-1:0] accept;
    EX_PACKET         comp_pkt [IN_CH];
    logic [NW-1:0]    comp_cnt;

    logic [CW-1:0]   npush;
    logic [CW-1:0]   nvalid;
    logic [CW-1:0]   npop;
    logic [CW-1:0]   pop_stored;
    logic [CW-1:0]   pop_bypass;
    logic [PW-1:0]   rd_idx [OUT_CH];
    logic [IN_CH-1:0] wr_en;
    logic [PW-1:0]   wr_idx [IN_CH];

    // in_ready depends only on registered occupancy, never on this cycle's traffic.
    assign in_ready = (count <= PUSH_LIMIT);
    assign accept   = in_valid & {IN_CH{in_ready}};

    ex_merge_fifo_lane_compactor #(
        .N (IN_CH)
    ) u_in_compactor (
        .valid   (accept),
        .packet  (in_packet),
        .compact (comp_pkt),
        .count   (comp_cnt)
    );

    assign npush = CW'(comp_cnt);

    always_comb begin
        for (int j = 0; j < OUT_CH; j++) begin
            rd_idx[j] = head + PW'(j);
        end
    end

    // Candidate order: stored entries from head, then this cycle's accepted inputs.
    always_comb begin
        for (int j = 0; j < OUT_CH; j++) begin
            out_valid[j]  = 1'b0;
            out_packet[j] = EX_PACKET_ZERO;
            if (CW'(j) < count) begin
                out_valid[j]  = 1'b1;
                out_packet[j] = mem[rd_idx[j]];
            end else if (BYPASS != 0) begin
                for (int i = 0; i < IN_CH; i++) begin
                    if ((CW'(i) < npush) && ((count + CW'(i)) == CW'(j))) begin
                        out_valid[j]  = 1'b1;
                        out_packet[j] = comp_pkt[i];
                    end
                end
            end
        end
        if (!reset_n) begin
            out_valid = '0;
            for (int j = 0; j < OUT_CH; j++) begin
                out_packet[j] = EX_PACKET_ZERO;
            end
        end
    end

    always_comb begin
        nvalid = '0;
        for (int j = 0; j < OUT_CH; j++) begin
            nvalid = nvalid + CW'(out_valid[j]);
        end
        npop       = out_ready ? nvalid : '0;
        pop_stored = (npop < count) ? npop : count;
        pop_bypass = npop - pop_stored;
    end

    // Inputs consumed by bypass are skipped; the rest land contiguously at tail.
    always_comb begin
        for (int i = 0; i < IN_CH; i++) begin
            wr_en[i]  = (CW'(i) >= pop_bypass) && (CW'(i) < npush);
            wr_idx[i] = tail + PW'(CW'(i) - pop_bypass);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= EX_PACKET_ZERO;
            end
        end else begin
            if ((|in_valid) && !in_ready) begin
                overflow_err <= 1'b1;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(pop_stored);
                tail  <= tail + PW'(npush - pop_bypass);
                count <= count + npush - npop;
                for (int i = 0; i < IN_CH; i++) begin
                    if (wr_en[i]) begin
                        mem[wr_idx[i]] <= comp_pkt[i];
                    end
                end
            end
        end
    end

endmodule
